cache_control: RTL
==================

# cache_control

Sequencing FSM for one 2-way set-associative L1 cache of 128-bit lines. It sits beside the cache datapath and resolves each CPU request as a hit, a clean miss or a dirty miss. It drives the line-merge/fill router (its `hit` and way-data select inputs), the per-way data/tag/valid/dirty/LRU write enables and the physical-memory handshake. It also keeps saturating performance counters.

## Interface
- `CNT_W`, 16, width of each performance counter
- `clk`  in  1  system clock, all state on rising edge
- `reset_n`  in  1  synchronous, active-low reset
- `mem_read`  in  1  CPU read request, held until `mem_resp`
- `mem_write`  in  1  CPU write request, held until `mem_resp`
- `hit0`, `hit1`  in  1 each  tag match AND valid for way 0/1 of the indexed set
- `dirty0`, `dirty1`  in  1 each  dirty bit of way 0/1 of the indexed set
- `lru`  in  1  least-recently-used way of the indexed set
- `pmem_resp`  in  1  physical memory done (one-cycle pulse)
- `mem_resp`  out  1  CPU request complete
- `pmem_read`, `pmem_write`  out  1 each  physical memory requests
- `pmem_addr_sel`  out  2  0 = CPU address, 1 = way0 tag+index, 2 = way1 tag+index
- `way_sel`  out  1  way whose data feeds router `way_data` and `pmem_wdata`
- `route_hit`  out  1  router `hit`: 1 = merge store bytes into way data, 0 = pass pmem line
- `load_way0`, `load_way1`  out  1 each  write data, tag and valid=1 into way 0/1
- `dirty_we0`, `dirty_we1`, `dirty_in`  out  1 each  dirty-bit writes
- `lru_we`, `lru_in`  out  1 each  LRU write; `lru_in` = way to evict next
- `hit_count`, `miss_count`, `wb_count`  out  `CNT_W` each  performance counters

## Operation
- States: IDLE, WRITEBACK, ALLOCATE. A registered `victim` bit is captured when IDLE detects a miss.
- Default outputs are 0, except `route_hit`=1 and `way_sel`=`victim`.
- IDLE, no request: hold.
- IDLE, request with `h` = the hitting way (`hit1` ? 1 : 0):
  - Read hit: `mem_resp`=1, `lru_we`=1, `lru_in`=~h.
  - Write hit: additionally `way_sel`=h, `route_hit`=1, `load_way<h>`=1, `dirty_we<h>`=1, `dirty_in`=1.
  - Increment `hit_count`.
- IDLE, request with neither hit:
  - `victim` <= `lru`; increment `miss_count`.
  - Next state WRITEBACK if `dirty[lru]`, else ALLOCATE.
- WRITEBACK:
  - `pmem_write`=1, `pmem_addr_sel`=1+`victim`, `way_sel`=`victim`.
  - On `pmem_resp`, go to ALLOCATE.
  - Increment `wb_count` on entry.
- ALLOCATE:
  - `pmem_read`=1, `pmem_addr_sel`=0, `route_hit`=0.
  - On `pmem_resp`: `load_way<victim>`=1, `dirty_we<victim>`=1, `dirty_in`=0; go to IDLE.
  - IDLE then re-evaluates and completes the request as a hit.
- `mem_read` and `mem_write` both high: treated as a write.
- A write hit with `mem_byte_enable`=00 still sets dirty.
- CPU request dropped mid-miss: the pmem transaction and the fill complete anyway; no `mem_resp` is issued.
- If `hit0` and `hit1` are both high (illegal), way 1 wins.
- Counters saturate at all-ones; they never wrap.

## Timing
- Reset (`reset_n`=0 at a clock edge):
  - State goes to IDLE, `victim`=0, all counters 0.
  - All outputs take their IDLE/no-request values from the next cycle, including mid-WRITEBACK or mid-ALLOCATE (pmem requests drop).
- Hit latency: 0 cycles. `mem_resp` is combinational in the cycle the request and hit coincide.
- Clean miss: request at cycle 0, ALLOCATE from cycle 1, `pmem_resp` at cycle k, IDLE at k+1, `mem_resp` at k+1.
- Dirty miss: WRITEBACK from cycle 1 to the first `pmem_resp` (cycle j); ALLOCATE from j+1 to the next `pmem_resp` (cycle m); `mem_resp` at m+1.
- `pmem_read`/`pmem_write` are held continuously until `pmem_resp`; they are never both high.
- `pmem_resp` outside WRITEBACK/ALLOCATE is ignored.
- `victim` is stable for the whole miss, even if `lru` changes.

## Test plan
- Read with `hit0`=1 at cycle 0 -> `mem_resp`=1 at cycle 0, `lru_we`=1, `lru_in`=1, `hit_count`=1.
- Write with `hit1`=1, byte_enable=01 -> `route_hit`=1, `way_sel`=1, `load_way1`=1, `dirty_we1`=1/`dirty_in`=1, `lru_in`=0, same cycle.
- Read miss, `lru`=0, `dirty0`=0, `pmem_resp` 4 cycles later -> ALLOCATE, `pmem_read`=1 cycles 1-4, `load_way0` with `route_hit`=0 at cycle 4, then `hit0` gives `mem_resp` at cycle 5, `miss_count`=1.
- Write miss, `lru`=1, `dirty1`=1 -> `pmem_write`/`pmem_addr_sel`=2/`way_sel`=1 until `pmem_resp`, then `pmem_read`, then fill, then merge hit; `wb_count`=1.
- `reset_n`=0 during ALLOCATE -> `pmem_read`=0 next cycle, state IDLE, all counters 0.
- Force 65 535 + 3 hits with `CNT_W`=16 -> `hit_count` stays 0xFFFF.

Source files
------------

// File: rtl/cache_control.sv
// Miss/hit sequencing FSM for a 2-way set-associative L1 cache with 128-bit lines.
// Also keeps saturating hit, miss and writeback counters.
module cache_control #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             mem_read,
  input  logic             mem_write,
  input  logic             hit0,
  input  logic             hit1,
  input  logic             dirty0,
  input  logic             dirty1,
  input  logic             lru,
  input  logic             pmem_resp,
  output logic             mem_resp,
  output logic             pmem_read,
  output logic             pmem_write,
  output logic [1:0]       pmem_addr_sel,
  output logic             way_sel,
  output logic             route_hit,
  output logic             load_way0,
  output logic             load_way1,
  output logic             dirty_we0,
  output logic             dirty_we1,
  output logic             dirty_in,
  output logic             lru_we,
  output logic             lru_in,
  output logic [CNT_W-1:0] hit_count,
  output logic [CNT_W-1:0] miss_count,
  output logic [CNT_W-1:0] wb_count
);

  typedef enum logic [1:0] {StIdle, StWriteback, StAllocate} state_e;

  state_e           state_q;
  logic             victim_q;
  logic [CNT_W-1:0] hit_cnt_q, miss_cnt_q, wb_cnt_q;

  logic req, any_hit, hit_way, lru_dirty;

  assign req       = mem_read | mem_write;
  assign any_hit   = hit0 | hit1;
  assign hit_way   = hit1;  // way 1 wins if both tags match
  assign lru_dirty = lru ? dirty1 : dirty0;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == {CNT_W{1'b1}}) ? c : c + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      victim_q   <= 1'b0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
      wb_cnt_q   <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (req && any_hit) begin
            hit_cnt_q <= sat_inc(hit_cnt_q);
          end else if (req) begin
            victim_q   <= lru;
            miss_cnt_q <= sat_inc(miss_cnt_q);
            if (lru_dirty) begin
              state_q  <= StWriteback;
              wb_cnt_q <= sat_inc(wb_cnt_q);
            end else begin
              state_q <= StAllocate;
            end
          end
        end
        StWriteback: if (pmem_resp) state_q <= StAllocate;
        StAllocate:  if (pmem_resp) state_q <= StIdle;
        default:     state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    mem_resp      = 1'b0;
    pmem_read     = 1'b0;
    pmem_write    = 1'b0;
    pmem_addr_sel = 2'd0;
    way_sel       = victim_q;
    route_hit     = 1'b1;
    load_way0     = 1'b0;
    load_way1     = 1'b0;
    dirty_we0     = 1'b0;
    dirty_we1     = 1'b0;
    dirty_in      = 1'b0;
    lru_we        = 1'b0;
    lru_in        = 1'b0;
    case (state_q)
      StIdle: begin
        if (req && any_hit) begin
          mem_resp = 1'b1;
          lru_we   = 1'b1;
          lru_in   = ~hit_way;
          if (mem_write) begin
            way_sel   = hit_way;
            load_way0 = ~hit_way;
            load_way1 = hit_way;
            dirty_we0 = ~hit_way;
            dirty_we1 = hit_way;
            dirty_in  = 1'b1;
          end
        end
      end
      StWriteback: begin
        pmem_write    = 1'b1;
        pmem_addr_sel = victim_q ? 2'd2 : 2'd1;
      end
      StAllocate: begin
        pmem_read = 1'b1;
        route_hit = 1'b0;
        if (pmem_resp) begin
          load_way0 = ~victim_q;
          load_way1 = victim_q;
          dirty_we0 = ~victim_q;
          dirty_we1 = victim_q;
        end
      end
      default: ;
    endcase
  end

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
  assign wb_count   = wb_cnt_q;

endmodule
